uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The parameter SHALL be SETTLE_CYCLES, default 4, the number of idle cycles between the TX write and the first status poll; the legal range is 3..15.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the rising CLK edge.
REQ-004 REQ0_VALID  input  1  requester 0 has a byte; SHALL be held with REQ0_DATA until REQ0_READY is seen.
REQ-005 REQ0_DATA  input  8  requester 0 transmit byte.
REQ-006 REQ0_READY  output  1  registered one-cycle pulse: requester 0 byte accepted.
REQ-007 REQ1_VALID  input  1  requester 1 has a byte; same rules as REQ0_VALID.
REQ-008 REQ1_DATA  input  8  requester 1 transmit byte.
REQ-009 REQ1_READY  output  1  registered one-cycle pulse: requester 1 byte accepted.
REQ-010 UART_ADDRESS  output  2  UART host register address.
REQ-011 UART_WDATA  output  8  UART host write data.
REQ-012 UART_RDATA  input  8  UART host read data (combinational from UART_ADDRESS); bit[1] is TX_BUSY.
REQ-013 UART_CS_n  output  1  UART chip select, active low.
REQ-014 UART_WR_n  output  1  UART write strobe, active low.
REQ-015 BUSY  output  1  high in every state except IDLE.
REQ-016 GRANT_ID  output  1  index of the requester whose byte is in flight or was last served.

Function
REQ-017 The state machine SHALL have exactly four states: IDLE, WRITE, SETTLE and POLL.
REQ-018 IDLE: when either VALID is high, the block SHALL select a winner, latch its DATA into an 8-bit hold register, set GRANT_ID, and move to WRITE on the next edge.
REQ-019 Arbitration SHALL be round-robin: if both VALIDs are high, the winner is the requester not equal to the last-granted index; if only one VALID is high, that requester wins.
REQ-020 The last-granted index SHALL update at the IDLE->WRITE transition.
REQ-021 WRITE lasts exactly 1 cycle, with UART_CS_n=0, UART_WR_n=0, UART_ADDRESS=2'h2, UART_WDATA=hold register.
REQ-022 In the WRITE cycle, READY of the granted requester SHALL be high and the other READY SHALL be low.
REQ-023 After WRITE, the block SHALL enter SETTLE.
REQ-024 SETTLE: UART_CS_n=1 and UART_WR_n=1; a 4-bit counter SHALL count SETTLE_CYCLES cycles, then the block SHALL move to POLL.
REQ-025 POLL: UART_CS_n=0, UART_WR_n=1, UART_ADDRESS=2'h1.
REQ-026 In POLL, if UART_RDATA[1]==0 at the clock edge, the next state SHALL be IDLE; otherwise the block SHALL stay in POLL.
REQ-027 The block SHALL never assert UART_CS_n=0 with UART_ADDRESS=2'h0, so the UART RX-available flag is never cleared.
REQ-028 The block SHALL never assert UART_CS_n=0 with UART_ADDRESS=2'h3.
REQ-029 Outside WRITE and POLL, outputs SHALL hold: UART_CS_n=1, UART_WR_n=1, UART_ADDRESS=2'h1, UART_WDATA=hold register.
REQ-030 A VALID that rises during BUSY SHALL be ignored until IDLE; no request SHALL be lost or duplicated.
REQ-031 After a grant, the first possible IDLE re-grant SHALL occur no earlier than 1+SETTLE_CYCLES+1 cycles after the WRITE cycle.
REQ-032 A VALID deasserted before its READY (protocol violation) SHALL have no effect on the latched byte.

Reset
REQ-033 While RESET=1, the block SHALL enter IDLE.
REQ-034 While RESET=1: REQ0_READY=0, REQ1_READY=0, BUSY=0, GRANT_ID=0, UART_CS_n=1, UART_WR_n=1, UART_ADDRESS=2'h1, UART_WDATA=8'h00, SETTLE counter=0.
REQ-035 While RESET=1, the last-granted index SHALL be 1, so requester 0 wins the first tie.
REQ-036 Reset in any state, including mid-POLL, SHALL abandon the poll; a byte already written to the UART is not recalled.

Verification
REQ-037 Single request: REQ0_VALID=1, REQ0_DATA=8'hA5 -> a WRITE cycle with UART_WDATA=8'hA5, ADDRESS=2, REQ0_READY pulse, GRANT_ID=0.
REQ-038 Tie after reset: both VALID high with 8'h11 and 8'h22 -> written in order 8'h11 then 8'h22; GRANT_ID goes 0 then 1; each READY pulses once.
REQ-039 Busy hold: UART model holds TX_BUSY=1 for 1000 cycles -> the block stays in POLL with ADDRESS=1 throughout, and no second WRITE occurs.
REQ-040 Settle timing: with SETTLE_CYCLES=4 -> the first POLL cycle is exactly 5 cycles after the WRITE cycle.
REQ-041 Reset mid-POLL -> the next cycle shows IDLE, CS_n=1, BUSY=0, and requester 0 wins the next tie.
REQ-042 Continuous assertion: CS_n=0 with ADDRESS=0 never occurs over 10k random requests.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter feeding bytes from two requesters into a UART host port (write, settle, poll TX_BUSY).
// Latency: byte latched on the IDLE grant edge, written to the UART the next cycle; next grant no earlier than SETTLE_CYCLES+2 cycles after the write.
// Backpressure: requesters hold VALID/DATA until a one-cycle READY pulse; requests seen while BUSY wait until IDLE.
module uart_tx_arbiter #(
    // Idle cycles between the TX write and the first status poll, legal range 3..15.
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    input  logic [7:0] REQ0_DATA,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [7:0] REQ1_DATA,
    output logic       REQ1_READY,
    output logic [1:0] UART_ADDRESS,
    output logic [7:0] UART_WDATA,
    input  logic [7:0] UART_RDATA,
    output logic       UART_CS_n,
    output logic       UART_WR_n,
    output logic       BUSY,
    output logic       GRANT_ID
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2,
        POLL   = 2'd3
    } state_t;

    // UART host register map as seen by this block.
    localparam logic [1:0] ADDR_STATUS = 2'h1;
    localparam logic [1:0] ADDR_TXDATA = 2'h2;

    // Terminal value of the settle counter; the counter runs 0..SETTLE_LAST.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ready_q, ready_d;

    logic       any_vld;
    logic       winner;
    logic       tx_busy;

    // Only TX_BUSY is consumed from the status register.
    logic       unused_rdata;
    assign unused_rdata = ^{UART_RDATA[7:2], UART_RDATA[0]};
    assign tx_busy      = UART_RDATA[1];

    // Round-robin pick: on a tie the requester that was not served last wins.
    always_comb begin
        any_vld = REQ0_VALID | REQ1_VALID;
        winner  = 1'b0;
        if (REQ0_VALID && REQ1_VALID) begin
            winner = ~last_q;
        end else begin
            winner = REQ1_VALID;
        end
    end

    // Next-state logic: grant in IDLE, one write cycle, counted settle, poll until TX idle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ready_d = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (any_vld) begin
                    state_d = WRITE;
                    hold_d  = winner ? REQ1_DATA : REQ0_DATA;
                    grant_d = winner;
                    last_d  = winner;
                    // READY is raised here so it is visible during the WRITE cycle.
                    ready_d = winner ? 2'b10 : 2'b01;
                end
            end
            WRITE: begin
                state_d = SETTLE;
                cnt_d   = 4'd0;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = POLL;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            POLL: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transfer and biases the first tie to requester 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            ready_q <= 2'b00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // UART bus decode from the registered state; address parks on STATUS so
    // CS_n is never low on the RX-data or unused register.
    always_comb begin
        UART_CS_n    = 1'b1;
        UART_WR_n    = 1'b1;
        UART_ADDRESS = ADDR_STATUS;
        UART_WDATA   = hold_q;
        unique case (state_q)
            WRITE: begin
                UART_CS_n    = 1'b0;
                UART_WR_n    = 1'b0;
                UART_ADDRESS = ADDR_TXDATA;
            end
            POLL: begin
                UART_CS_n    = 1'b0;
            end
            default: begin
                UART_CS_n    = 1'b1;
            end
        endcase
    end

    assign REQ0_READY = ready_q[0];
    assign REQ1_READY = ready_q[1];
    assign BUSY       = (state_q != IDLE);
    assign GRANT_ID   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timing model driven by distance from the last write.
// Requesters are driven at posedge+1, outputs are sampled at negedge.
// A simple UART model holds TX_BUSY for a programmable number of cycles after each write.
module tb_uart_tx_arbiter;

    localparam int S = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] vld;
    logic [7:0] dat0, dat1;
    logic       REQ0_READY, REQ1_READY;
    logic [1:0] UART_ADDRESS;
    logic [7:0] UART_WDATA;
    logic [7:0] rdata;
    logic       UART_CS_n, UART_WR_n, BUSY, GRANT_ID;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(.SETTLE_CYCLES(S)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ0_VALID   (vld[0]),
        .REQ0_DATA    (dat0),
        .REQ0_READY   (REQ0_READY),
        .REQ1_VALID   (vld[1]),
        .REQ1_DATA    (dat1),
        .REQ1_READY   (REQ1_READY),
        .UART_ADDRESS (UART_ADDRESS),
        .UART_WDATA   (UART_WDATA),
        .UART_RDATA   (rdata),
        .UART_CS_n    (UART_CS_n),
        .UART_WR_n    (UART_WR_n),
        .BUSY         (BUSY),
        .GRANT_ID     (GRANT_ID)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // UART model: TX_BUSY stays high for busy_len cycles after a write.
    int         busy_len;
    int         busy_cnt = 0;
    logic [7:0] junk = 8'h00;
    always @(posedge CLK) begin
        junk <= 8'($urandom);
        if (!UART_CS_n && !UART_WR_n) busy_cnt <= busy_len;
        else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
    end
    always_comb begin
        rdata = junk;
        if (UART_ADDRESS == 2'h1) rdata[1] = (busy_cnt != 0);
    end

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         sb0 = 0, sb1 = 0;
    int         wlog_c[$];
    logic [7:0] wlog_d[$];
    logic       wlog_g[$];
    int         plog[$];
    logic [1:0] rdy_s = 2'b00;
    int         rc0 = 0, rc1 = 0;
    bit         rand_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic post(input int i, input logic [7:0] d);
        if (i == 0) begin vld[0] = 1'b1; dat0 = d; exp_q0.push_back(d); end
        else        begin vld[1] = 1'b1; dat1 = d; exp_q1.push_back(d); end
    endtask

    // One clock step: release requests that saw READY, then optional random traffic.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (rdy_s[0]) vld[0] = 1'b0;
        if (rdy_s[1]) vld[1] = 1'b0;
        if (rand_on) begin
            if (!vld[0] && $urandom_range(0, 3) == 0) post(0, 8'($urandom));
            if (!vld[1] && $urandom_range(0, 3) == 0) post(1, 8'($urandom));
            busy_len = int'($urandom_range(0, 12));
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wlog_d.size() < n && k < budget) begin tick(); k++; end
        chk("write_seen", 32'(wlog_d.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((BUSY || vld != 2'b00) && k < budget) begin tick(); k++; end
        chk("idle_reached", {30'd0, BUSY, |vld}, 32'd0);
    endtask

    // Reference model: expected outputs follow from the cycle distance to the last write.
    task automatic monitor();
        bit         m_idle = 1'b1;
        bit         m_last = 1'b1;
        bit         m_grant = 1'b0;
        logic [7:0] m_hold = 8'h00;
        int         m_wr = 0;
        int         d;
        bit         w;
        bit         prev_cs = 1'b1;
        logic [15:0] got, exp;
        forever begin
            @(negedge CLK);
            exp = {2'b00, 1'b0, m_grant, 1'b1, 1'b1, 2'h1, m_hold};
            if (!m_idle) begin
                d = cyc - m_wr;
                if (d == 0)      exp = {(m_grant ? 2'b10 : 2'b01), 1'b1, m_grant, 1'b0, 1'b0, 2'h2, m_hold};
                else if (d <= S) exp = {2'b00, 1'b1, m_grant, 1'b1, 1'b1, 2'h1, m_hold};
                else             exp = {2'b00, 1'b1, m_grant, 1'b0, 1'b1, 2'h1, m_hold};
            end
            got = {REQ1_READY, REQ0_READY, BUSY, GRANT_ID, UART_CS_n, UART_WR_n, UART_ADDRESS, UART_WDATA};
            chk("cycle_outputs", {16'd0, got}, {16'd0, exp});
            chk("cs_addr_legal", 32'(!UART_CS_n && (UART_ADDRESS == 2'h0 || UART_ADDRESS == 2'h3)), 32'd0);

            if (!UART_CS_n && !UART_WR_n) begin
                if (GRANT_ID) begin
                    chk("req1_queue_depth", 32'(sb1 < exp_q1.size()), 32'd1);
                    if (sb1 < exp_q1.size()) chk("wdata_req1", {24'd0, UART_WDATA}, {24'd0, exp_q1[sb1]});
                    sb1++;
                end else begin
                    chk("req0_queue_depth", 32'(sb0 < exp_q0.size()), 32'd1);
                    if (sb0 < exp_q0.size()) chk("wdata_req0", {24'd0, UART_WDATA}, {24'd0, exp_q0[sb0]});
                    sb0++;
                end
                wlog_c.push_back(cyc);
                wlog_d.push_back(UART_WDATA);
                wlog_g.push_back(GRANT_ID);
            end
            if (!UART_CS_n && UART_WR_n && prev_cs) plog.push_back(cyc);
            prev_cs = UART_CS_n;
            rdy_s = {REQ1_READY, REQ0_READY};
            rc0 += int'(REQ0_READY);
            rc1 += int'(REQ1_READY);

            if (RESET) begin
                m_idle = 1'b1; m_last = 1'b1; m_grant = 1'b0; m_hold = 8'h00;
            end else if (m_idle) begin
                if (vld != 2'b00) begin
                    w = (vld == 2'b11) ? !m_last : vld[1];
                    m_grant = w;
                    m_last  = w;
                    m_hold  = w ? dat1 : dat0;
                    m_wr    = cyc + 1;
                    m_idle  = 1'b0;
                end
            end else if (cyc - m_wr > S && !rdata[1]) begin
                m_idle = 1'b1;
            end
        end
    endtask

    task automatic run_main();
        int n0, p0, r0, r1;
        repeat (3) tick();
        chk("reset_state", {18'd0, BUSY, GRANT_ID, UART_CS_n, UART_WR_n, UART_ADDRESS, UART_WDATA, REQ1_READY, REQ0_READY},
            {18'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'h1, 8'h00, 2'b00});
        RESET = 1'b0;

        // Single request and settle timing.
        n0 = wlog_d.size(); p0 = plog.size();
        post(0, 8'hA5);
        wait_writes(n0 + 1, 50);
        chk("single_wdata", {24'd0, wlog_d[n0]}, 32'h0000_00A5);
        chk("single_grant", {31'd0, wlog_g[n0]}, 32'd0);
        begin
            int k = 0;
            while (plog.size() <= p0 && k < 50) begin tick(); k++; end
        end
        chk("poll_seen", 32'(plog.size() > p0), 32'd1);
        if (plog.size() > p0) chk("poll_after_write", 32'(plog[p0] - wlog_c[n0]), 32'd5);
        wait_idle(100);

        // Tie right after reset: requester 0 first, then 1.
        RESET = 1'b1; tick(); tick(); RESET = 1'b0;
        n0 = wlog_d.size(); r0 = rc0; r1 = rc1;
        post(0, 8'h11); post(1, 8'h22);
        wait_writes(n0 + 2, 100);
        chk("tie_first_data",  {24'd0, wlog_d[n0]},     32'h11);
        chk("tie_first_grant", {31'd0, wlog_g[n0]},     32'd0);
        chk("tie_second_data", {24'd0, wlog_d[n0 + 1]}, 32'h22);
        chk("tie_second_grant",{31'd0, wlog_g[n0 + 1]}, 32'd1);
        wait_idle(100);
        chk("tie_ready0_pulses", 32'(rc0 - r0), 32'd1);
        chk("tie_ready1_pulses", 32'(rc1 - r1), 32'd1);

        // Long TX_BUSY: stays in POLL, the waiting request is not written.
        busy_len = 1000;
        n0 = wlog_d.size();
        post(0, 8'h3C);
        wait_writes(n0 + 1, 50);
        tick();
        post(1, 8'h5A);
        repeat (990) tick();
        chk("busy_hold_writes", 32'(wlog_d.size()), 32'(n0 + 1));
        chk("busy_hold_poll", {29'd0, UART_CS_n, UART_ADDRESS}, {29'd0, 1'b0, 2'h1});
        busy_len = 0;
        wait_writes(n0 + 2, 100);
        chk("busy_release_data",  {24'd0, wlog_d[n0 + 1]}, 32'h5A);
        chk("busy_release_grant", {31'd0, wlog_g[n0 + 1]}, 32'd1);
        wait_idle(100);

        // Short VALID glitch while busy leaves the latched byte alone.
        n0 = wlog_d.size();
        post(0, 8'h77);
        wait_writes(n0 + 1, 50);
        tick();
        vld[1] = 1'b1; dat1 = 8'hEE;
        tick();
        vld[1] = 1'b0; dat1 = 8'h00;
        wait_idle(100);
        chk("glitch_hold", {24'd0, UART_WDATA}, 32'h77);
        chk("glitch_writes", 32'(wlog_d.size()), 32'(n0 + 1));

        // Reset in the middle of POLL, then a tie goes to requester 0.
        busy_len = 50;
        n0 = wlog_d.size();
        post(1, 8'h99);
        wait_writes(n0 + 1, 50);
        repeat (S + 3) tick();
        chk("midpoll_state", {29'd0, UART_CS_n, UART_ADDRESS}, {29'd0, 1'b0, 2'h1});
        busy_len = 0;
        post(0, 8'hA1); post(1, 8'hB2);
        RESET = 1'b1;
        tick();
        chk("midpoll_reset", {29'd0, BUSY, UART_CS_n, GRANT_ID}, {29'd0, 1'b0, 1'b1, 1'b0});
        RESET = 1'b0;
        wait_writes(n0 + 3, 100);
        chk("post_reset_grant0", {31'd0, wlog_g[n0 + 1]}, 32'd0);
        chk("post_reset_data0",  {24'd0, wlog_d[n0 + 1]}, 32'hA1);
        chk("post_reset_grant1", {31'd0, wlog_g[n0 + 2]}, 32'd1);
        chk("post_reset_data1",  {24'd0, wlog_d[n0 + 2]}, 32'hB2);
        wait_idle(100);

        // Random traffic with random TX_BUSY lengths.
        rand_on = 1'b1;
        repeat (20000) tick();
        rand_on = 1'b0;
        wait_idle(3000);
        chk("all_req0_written", 32'(sb0), 32'(exp_q0.size()));
        chk("all_req1_written", 32'(sb1), 32'(exp_q1.size()));
    endtask

    initial begin
        RESET = 1'b1;
        vld = 2'b00;
        dat0 = 8'h00;
        dat1 = 8'h00;
        busy_len = 0;
        fork
            monitor();
            run_main();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
